stack_frame_engine: RTL and testbench
=====================================

Name: stack_frame_engine

Overview:
- Memory-side responder for the control unit's call, interrupt, return and return-from-interrupt requests.
- Accepts one frame command at a time. Sequences the individual 16-bit stack word writes and reads on a single-port synchronous data memory, and owns the stack pointer.
- Reassembles the popped PC and CCR and returns them to the fetch stage and the flag register.
- Sits between the control unit and the data memory arbiter.

Parameters:
- ADDR_W, 11, memory word-address width.
- SP_INIT, 2**ADDR_W-1, stack pointer value after reset (top of stack; stack grows downward).
- STACK_LIMIT, 0, lowest address a push may write.
- CCR_W, 3, condition-code width.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge).
- cmd_valid  in  1  command request.
- cmd_op  in  2  00 CALL, 01 INT, 10 RET, 11 RTI.
- cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid&&cmd_ready.
- pc_in  in  32  PC to push; sampled at accept.
- ccr_in  in  CCR_W  flags to push on INT; sampled at accept.
- pc_out  out  32  popped PC; holds until the next pop.
- pc_valid  out  1  one-cycle pulse, pc_out is new.
- ccr_out  out  CCR_W  popped flags.
- ccr_valid  out  1  one-cycle pulse (RTI only).
- done  out  1  one-cycle pulse at the end of every accepted command.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  16  write data.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe; mem_rdata is valid on the cycle after mem_re.
- mem_rdata  in  16  read data.
- sp  out  ADDR_W  current stack pointer.
- ovf_err  out  1  sticky push-overflow flag.
- unf_err  out  1  sticky pop-underflow flag.

Behaviour:
- Reset values: sp=SP_INIT, state IDLE, cmd_ready=1.
- Reset values: pc_out=0, ccr_out=0, all pulses/strobes/errors=0, mem_addr=0, mem_wdata=0.
- Push word: mem_addr=sp, mem_we=1, sp<=sp-1.
- Pop word: mem_addr=sp+1, mem_re=1, sp<=sp+1. The data is captured on the following cycle.
- Frame word order on push: PC[31:16], then PC[15:0], then {zero-pad, CCR} (INT only).
- Frame word order on pop: the exact reverse of the push order.
- States: IDLE, PUSH_HI, PUSH_LO, PUSH_CCR, POP_CCR, POP_LO, POP_HI, CAP_HI, DONE.
- CALL: IDLE -> PUSH_HI -> PUSH_LO -> DONE.
- INT: IDLE -> PUSH_HI -> PUSH_LO -> PUSH_CCR -> DONE.
- RET: IDLE -> POP_LO -> POP_HI (capture low half) -> CAP_HI (capture high half) -> DONE.
- RTI: IDLE -> POP_CCR -> POP_LO (capture ccr) -> POP_HI (capture low half) -> CAP_HI (capture high half) -> DONE.
- DONE: done=1. pc_valid=1 for RET/RTI; ccr_valid=1 for RTI. Returns to IDLE the next cycle.
- Latency: the first memory strobe occurs the cycle after accept. done occurs 3/4/4/5 cycles after accept for CALL/INT/RET/RTI.
- cmd_valid while not in IDLE is ignored; no queuing.
- At most one of mem_we/mem_re is high in any cycle; both are low in IDLE and DONE.
- Bounds check (under the macro), evaluated at accept with N = frame word count:
  - Push is legal if sp-(N-1) >= STACK_LIMIT.
  - Pop is legal if sp+N <= SP_INIT.
- Illegal frame: go directly to DONE and pulse done only. No memory strobes, sp unchanged, pc/ccr_valid=0. Set ovf_err or unf_err.
- Error flags clear only on reset.
- Reset mid-command: abort immediately. sp returns to SP_INIT. No strobe occurs on the cycle after rst==0 is sampled; a partially pushed frame is discarded.

Optional Feature:
- Macro STACK_BOUNDS_CHECK_EN.
- Defined: legality checks and sticky error flags as above.
- Undefined:
  - No checks; every frame executes.
  - sp wraps modulo 2**ADDR_W (SP_INIT+1 becomes 0; 0-1 becomes 2**ADDR_W-1).
  - ovf_err/unf_err are tied to 0.

Test Plan:
- Reset then idle -> sp=0x7FF, cmd_ready=1, all strobes and pulses 0.
- CALL pc_in=0x0001_2345 -> writes 0x7FF<=0x0001, then 0x7FE<=0x2345; sp=0x7FD; done 3 cycles after accept.
- RET following that CALL (mem returns written values) -> reads 0x7FE then 0x7FF; pc_out=0x0001_2345 with pc_valid 4 cycles after accept; sp=0x7FF.
- INT pc_in=0xABCD_0010, ccr_in=3'b101, then RTI -> writes 0xABCD, 0x0010, 0x0005 at 0x7FF..0x7FD.
  - RTI then yields ccr_out=5 and pc_out=0xABCD_0010, both valids in the same cycle; sp=0x7FF.
- STACK_LIMIT=0x7FE with macro defined, INT at sp=0x7FF -> no mem_we, ovf_err=1, done pulses, sp=0x7FF.
  - RET at sp=0x7FF -> unf_err=1.
  - Macro undefined: the same INT writes 0x7FF, 0x7FE, 0x7FD and sp=0x7FC.
- rst=0 the cycle after the first INT write -> sp=0x7FF, no further writes.
  - cmd_valid pulsed during a busy RET is ignored: no second done.

Source files
------------

// File: rtl/stack_frame_engine_if.sv
// Command and data-memory bus of the stack frame engine.
// slave is the engine's view; master is the control unit / memory arbiter side.
interface stack_frame_engine_if #(
    parameter int ADDR_W = 11,
    parameter int CCR_W  = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [31:0]       pc_in;
    logic [CCR_W-1:0]  ccr_in;
    logic [31:0]       pc_out;
    logic              pc_valid;
    logic [CCR_W-1:0]  ccr_out;
    logic              ccr_valid;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [15:0]       mem_rdata;
    logic [ADDR_W-1:0] sp;
    logic              ovf_err;
    logic              unf_err;

    modport slave (
        input  cmd_valid, cmd_op, pc_in, ccr_in, mem_rdata,
        output cmd_ready, pc_out, pc_valid, ccr_out, ccr_valid, done,
               mem_addr, mem_wdata, mem_we, mem_re, sp, ovf_err, unf_err
    );

    modport master (
        output cmd_valid, cmd_op, pc_in, ccr_in, mem_rdata,
        input  cmd_ready, pc_out, pc_valid, ccr_out, ccr_valid, done,
               mem_addr, mem_wdata, mem_we, mem_re, sp, ovf_err, unf_err
    );
endinterface

// File: rtl/stack_frame_engine.sv
// Pushes/pops CALL, INT, RET and RTI frames as 16-bit words on a downward-growing stack.
// Define STACK_BOUNDS_CHECK_EN for frame bounds checking and sticky ovf_err/unf_err flags.
module stack_frame_engine #(
    parameter int ADDR_W      = 11,
    parameter int SP_INIT     = 2**ADDR_W - 1,
    parameter int STACK_LIMIT = 0,
    parameter int CCR_W       = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    stack_frame_engine_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, PUSH_HI, PUSH_LO, PUSH_CCR, POP_CCR, POP_LO, POP_HI, CAP_HI, DONE
    } state_t;

    typedef enum logic [1:0] {OP_CALL = 2'b00, OP_INT = 2'b01, OP_RET = 2'b10, OP_RTI = 2'b11} op_t;

    state_t            state, next_state;
    op_t               op_q;
    logic [31:0]       pc_q, pc_out_q;
    logic [CCR_W-1:0]  ccr_q, ccr_out_q;
    logic [ADDR_W-1:0] sp_q;
    logic              exec_q;
    logic              frame_ok;

    logic              accept, cmd_ready, mem_we, mem_re, done, pc_valid, ccr_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        cmd_ready  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        done       = 1'b0;
        pc_valid   = 1'b0;
        ccr_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept = 1'b1;
                    if (!frame_ok)            next_state = DONE;
                    else if (!bus.cmd_op[1])  next_state = PUSH_HI;
                    else if (bus.cmd_op[0])   next_state = POP_CCR;
                    else                      next_state = POP_LO;
                end
            end
            PUSH_HI: begin
                mem_we     = 1'b1;
                mem_addr   = sp_q;
                mem_wdata  = pc_q[31:16];
                next_state = PUSH_LO;
            end
            PUSH_LO: begin
                mem_we     = 1'b1;
                mem_addr   = sp_q;
                mem_wdata  = pc_q[15:0];
                next_state = (op_q == OP_INT) ? PUSH_CCR : DONE;
            end
            PUSH_CCR: begin
                mem_we     = 1'b1;
                mem_addr   = sp_q;
                mem_wdata  = 16'(ccr_q);
                next_state = DONE;
            end
            POP_CCR: begin
                mem_re     = 1'b1;
                mem_addr   = sp_q + 1'b1;
                next_state = POP_LO;
            end
            POP_LO: begin
                mem_re     = 1'b1;
                mem_addr   = sp_q + 1'b1;
                next_state = POP_HI;
            end
            POP_HI: begin
                mem_re     = 1'b1;
                mem_addr   = sp_q + 1'b1;
                next_state = CAP_HI;
            end
            CAP_HI:  next_state = DONE;
            DONE: begin
                done       = 1'b1;
                pc_valid   = exec_q && op_q[1];
                ccr_valid  = exec_q && (op_q == OP_RTI);
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sp_q      <= ADDR_W'(SP_INIT);
            op_q      <= OP_CALL;
            pc_q      <= '0;
            ccr_q     <= '0;
            pc_out_q  <= '0;
            ccr_out_q <= '0;
            exec_q    <= 1'b0;
        end else begin
            state <= next_state;
            if (mem_we)      sp_q <= sp_q - 1'b1;
            else if (mem_re) sp_q <= sp_q + 1'b1;
            if (accept) begin
                op_q   <= op_t'(bus.cmd_op);
                pc_q   <= bus.pc_in;
                ccr_q  <= bus.ccr_in;
                exec_q <= frame_ok;
            end
            // Read data lags its strobe by one cycle, so each half lands one state later.
            if (state == POP_LO && op_q == OP_RTI) ccr_q <= bus.mem_rdata[CCR_W-1:0];
            if (state == POP_HI) pc_q[15:0] <= bus.mem_rdata;
            if (state == CAP_HI) begin
                pc_out_q <= {bus.mem_rdata, pc_q[15:0]};
                if (op_q == OP_RTI) ccr_out_q <= ccr_q;
            end
        end
    end

`ifdef STACK_BOUNDS_CHECK_EN
    localparam int XW = ADDR_W + 2;
    logic [XW-1:0] sp_x, words;
    logic          ovf_q, unf_q;

    always_comb begin
        sp_x  = XW'(sp_q);
        words = bus.cmd_op[0] ? XW'(3) : XW'(2);
        if (bus.cmd_op[1]) frame_ok = (sp_x + words) <= XW'(SP_INIT);
        else               frame_ok = sp_x >= (XW'(STACK_LIMIT) + words - XW'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (accept && !frame_ok) begin
            if (bus.cmd_op[1]) unf_q <= 1'b1;
            else               ovf_q <= 1'b1;
        end
    end

    assign bus.ovf_err = ovf_q;
    assign bus.unf_err = unf_q;
`else
    assign frame_ok    = 1'b1;
    assign bus.ovf_err = 1'b0;
    assign bus.unf_err = 1'b0;
`endif

    assign bus.cmd_ready = cmd_ready;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_we    = mem_we;
    assign bus.mem_re    = mem_re;
    assign bus.done      = done;
    assign bus.pc_valid  = pc_valid;
    assign bus.ccr_valid = ccr_valid;
    assign bus.pc_out    = pc_out_q;
    assign bus.ccr_out   = ccr_out_q;
    assign bus.sp        = sp_q;
endmodule

// File: tb/tb_stack_frame_engine.sv
// Directed bench: dut_a uses default limits, dut_b uses STACK_LIMIT=0x7FE for the boundary cases.
`timescale 1ns/1ps
module tb_stack_frame_engine;
    localparam int ADDR_W = 11;
    localparam int CCR_W  = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stack_frame_engine_if #(.ADDR_W(ADDR_W), .CCR_W(CCR_W)) a_if ();
    stack_frame_engine_if #(.ADDR_W(ADDR_W), .CCR_W(CCR_W)) b_if ();

    stack_frame_engine #(.ADDR_W(ADDR_W), .CCR_W(CCR_W)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if.slave)
    );
    stack_frame_engine #(.ADDR_W(ADDR_W), .STACK_LIMIT('h7FE), .CCR_W(CCR_W)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if.slave)
    );

    logic              sel, vld;
    logic [1:0]        op_d;
    logic [31:0]       pc_d;
    logic [CCR_W-1:0]  ccr_d;

    assign a_if.cmd_valid = vld & ~sel;
    assign b_if.cmd_valid = vld & sel;
    assign a_if.cmd_op    = op_d;
    assign b_if.cmd_op    = op_d;
    assign a_if.pc_in     = pc_d;
    assign b_if.pc_in     = pc_d;
    assign a_if.ccr_in    = ccr_d;
    assign b_if.ccr_in    = ccr_d;

    logic [15:0] mem_a [2**ADDR_W];
    logic [15:0] mem_b [2**ADDR_W];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else begin
            if (a_if.mem_we) mem_a[a_if.mem_addr] <= a_if.mem_wdata;
            if (b_if.mem_we) mem_b[b_if.mem_addr] <= b_if.mem_wdata;
        end
        if (a_if.mem_re) a_if.mem_rdata <= mem_a[a_if.mem_addr];
        if (b_if.mem_re) b_if.mem_rdata <= mem_b[b_if.mem_addr];
    end

    wr_t               wq_a[$], wq_b[$];
    logic [ADDR_W-1:0] rq_a[$], rq_b[$];
    int                done_a = 0, done_b = 0;

    always @(negedge clk) begin
        if (a_if.mem_we) wq_a.push_back({a_if.mem_addr, a_if.mem_wdata});
        if (b_if.mem_we) wq_b.push_back({b_if.mem_addr, b_if.mem_wdata});
        if (a_if.mem_re) rq_a.push_back(a_if.mem_addr);
        if (b_if.mem_re) rq_b.push_back(b_if.mem_addr);
        if (a_if.done) done_a++;
        if (b_if.done) done_b++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one command and returns the accept-to-done latency and the valids seen with done.
    task automatic run_cmd(input logic s, input logic [1:0] op, input logic [31:0] pc,
                           input logic [CCR_W-1:0] ccr, input int poke,
                           output int lat, output logic pv, output logic cv);
        @(negedge clk);
        sel = s; op_d = op; pc_d = pc; ccr_d = ccr;
        wq_a.delete(); wq_b.delete(); rq_a.delete(); rq_b.delete();
        vld = 1'b1;
        @(negedge clk);
        lat = 0; pv = 1'b0; cv = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            vld = (i == poke);
            if (sel ? b_if.done : a_if.done) begin
                lat = i;
                pv  = sel ? b_if.pc_valid  : a_if.pc_valid;
                cv  = sel ? b_if.ccr_valid : a_if.ccr_valid;
                break;
            end
            @(negedge clk);
        end
        vld = 1'b0;
        check("done_seen", 32'(lat != 0), 32'd1);
        @(negedge clk);
    endtask

    int   lat, d0;
    logic pv, cv;

    initial begin
        sel = 1'b0; vld = 1'b0; op_d = '0; pc_d = '0; ccr_d = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        check("rst_sp",        32'(a_if.sp),        32'h7FF);
        check("rst_ready",     32'(a_if.cmd_ready), 32'd1);
        check("rst_we",        32'(a_if.mem_we),    32'd0);
        check("rst_re",        32'(a_if.mem_re),    32'd0);
        check("rst_done",      32'(a_if.done),      32'd0);
        check("rst_pc_valid",  32'(a_if.pc_valid),  32'd0);
        check("rst_ccr_valid", 32'(a_if.ccr_valid), 32'd0);
        check("rst_addr",      32'(a_if.mem_addr),  32'd0);
        check("rst_wdata",     32'(a_if.mem_wdata), 32'd0);
        check("rst_pc_out",    a_if.pc_out,         32'd0);
        check("rst_ccr_out",   32'(a_if.ccr_out),   32'd0);
        check("rst_ovf",       32'(a_if.ovf_err),   32'd0);
        check("rst_unf",       32'(a_if.unf_err),   32'd0);

        run_cmd(1'b0, 2'b00, 32'h0001_2345, 3'd0, 0, lat, pv, cv);
        check("call_lat", lat,                 32'd3);
        check("call_nwr", wq_a.size(),         32'd2);
        check("call_wr0", 32'(wq_a[0]),        {5'd0, 11'h7FF, 16'h0001});
        check("call_wr1", 32'(wq_a[1]),        {5'd0, 11'h7FE, 16'h2345});
        check("call_nrd", rq_a.size(),         32'd0);
        check("call_pv",  32'(pv),             32'd0);
        check("call_sp",  32'(a_if.sp),        32'h7FD);

        run_cmd(1'b0, 2'b10, 32'h0, 3'd0, 0, lat, pv, cv);
        check("ret_lat", lat,            32'd4);
        check("ret_nrd", rq_a.size(),    32'd2);
        check("ret_rd0", 32'(rq_a[0]),   32'h7FE);
        check("ret_rd1", 32'(rq_a[1]),   32'h7FF);
        check("ret_nwr", wq_a.size(),    32'd0);
        check("ret_pc",  a_if.pc_out,    32'h0001_2345);
        check("ret_pv",  32'(pv),        32'd1);
        check("ret_cv",  32'(cv),        32'd0);
        check("ret_sp",  32'(a_if.sp),   32'h7FF);

        run_cmd(1'b0, 2'b01, 32'hABCD_0010, 3'b101, 0, lat, pv, cv);
        check("int_lat", lat,            32'd4);
        check("int_nwr", wq_a.size(),    32'd3);
        check("int_wr0", 32'(wq_a[0]),   {5'd0, 11'h7FF, 16'hABCD});
        check("int_wr1", 32'(wq_a[1]),   {5'd0, 11'h7FE, 16'h0010});
        check("int_wr2", 32'(wq_a[2]),   {5'd0, 11'h7FD, 16'h0005});
        check("int_sp",  32'(a_if.sp),   32'h7FC);

        run_cmd(1'b0, 2'b11, 32'h0, 3'd0, 0, lat, pv, cv);
        check("rti_lat", lat,              32'd5);
        check("rti_nrd", rq_a.size(),      32'd3);
        check("rti_rd0", 32'(rq_a[0]),     32'h7FD);
        check("rti_rd2", 32'(rq_a[2]),     32'h7FF);
        check("rti_pc",  a_if.pc_out,      32'hABCD_0010);
        check("rti_ccr", 32'(a_if.ccr_out), 32'd5);
        check("rti_pv",  32'(pv),          32'd1);
        check("rti_cv",  32'(cv),          32'd1);
        check("rti_sp",  32'(a_if.sp),     32'h7FF);

        // A CALL request raised while the RET is in flight must be dropped.
        run_cmd(1'b0, 2'b00, 32'h1234_5678, 3'd0, 0, lat, pv, cv);
        d0 = done_a;
        run_cmd(1'b0, 2'b10, 32'h0, 3'd0, 2, lat, pv, cv);
        repeat (4) @(negedge clk);
        check("busy_ndone", done_a - d0,  32'd1);
        check("busy_nwr",   wq_a.size(),  32'd0);
        check("busy_pc",    a_if.pc_out,  32'h1234_5678);
        check("busy_sp",    32'(a_if.sp), 32'h7FF);

        run_cmd(1'b1, 2'b00, 32'h1111_2222, 3'd0, 0, lat, pv, cv);
        check("b_call_lat", lat,          32'd3);
        check("b_call_nwr", wq_b.size(),  32'd2);
        check("b_call_sp",  32'(b_if.sp), 32'h7FD);
        run_cmd(1'b1, 2'b10, 32'h0, 3'd0, 0, lat, pv, cv);
        check("b_ret_pc",   b_if.pc_out,  32'h1111_2222);
        check("b_ret_sp",   32'(b_if.sp), 32'h7FF);

        run_cmd(1'b1, 2'b01, 32'hABCD_0010, 3'b101, 0, lat, pv, cv);
`ifdef STACK_BOUNDS_CHECK_EN
        check("b_int_lat", lat,              32'd1);
        check("b_int_nwr", wq_b.size(),      32'd0);
        check("b_int_ovf", 32'(b_if.ovf_err), 32'd1);
        check("b_int_unf", 32'(b_if.unf_err), 32'd0);
        check("b_int_sp",  32'(b_if.sp),     32'h7FF);
        run_cmd(1'b1, 2'b10, 32'h0, 3'd0, 0, lat, pv, cv);
        check("b_ret_lat", lat,              32'd1);
        check("b_ret_nrd", rq_b.size(),      32'd0);
        check("b_ret_pv",  32'(pv),          32'd0);
        check("b_ret_unf", 32'(b_if.unf_err), 32'd1);
        check("b_ovf_hold", 32'(b_if.ovf_err), 32'd1);
        check("b_ret_sp",  32'(b_if.sp),     32'h7FF);
`else
        check("b_int_lat", lat,              32'd4);
        check("b_int_nwr", wq_b.size(),      32'd3);
        check("b_int_wr2", 32'(wq_b[2]),     {5'd0, 11'h7FD, 16'h0005});
        check("b_int_ovf", 32'(b_if.ovf_err), 32'd0);
        check("b_int_sp",  32'(b_if.sp),     32'h7FC);
        run_cmd(1'b1, 2'b10, 32'h0, 3'd0, 0, lat, pv, cv);
        check("b_ret_pc",  b_if.pc_out,      32'h0010_0005);
        check("b_ret_unf", 32'(b_if.unf_err), 32'd0);
        check("b_ret_sp",  32'(b_if.sp),     32'h7FE);
        run_cmd(1'b1, 2'b10, 32'h0, 3'd0, 0, lat, pv, cv);
        check("b_wrap_rd1", 32'(rq_b[1]),    32'h000);
        check("b_wrap_pc",  b_if.pc_out,     32'h0000_ABCD);
        check("b_wrap_sp",  32'(b_if.sp),    32'h000);
`endif

        // Reset lands during the second push word of an INT.
        @(negedge clk);
        sel = 1'b0; op_d = 2'b01; pc_d = 32'hCAFE_F00D; ccr_d = 3'd2;
        wq_a.delete();
        d0 = done_a;
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst_mid_sp", 32'(a_if.sp), 32'h7FF);
        repeat (4) @(negedge clk);
        check("rst_mid_nwr",   wq_a.size(),          32'd2);
        check("rst_mid_wr0",   32'(wq_a[0]),         {5'd0, 11'h7FF, 16'hCAFE});
        check("rst_mid_done",  done_a - d0,          32'd0);
        check("rst_mid_ready", 32'(a_if.cmd_ready),  32'd1);
        check("rst_mid_sp2",   32'(a_if.sp),         32'h7FF);
        check("rst_b_ovf",     32'(b_if.ovf_err),    32'd0);
        check("rst_b_sp",      32'(b_if.sp),         32'h7FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
